// File: rtl/shifter_pipelined.sv
// Pipelined log-shifter: one stage per shamt bit, each followed by a register.
// Supports SLL, SRL, SRA and ROL, with a valid/ready handshake on both sides.
module shifter_pipelined #(
  parameter  int N = 32,
  localparam int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [L-1:0] shamt,
  input  logic [1:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
);

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  logic advance;

  // The SRA fill comes from the sign bit captured at entry, not from the
  // partially shifted operand.
  function automatic logic [N-1:0] shift_by(input logic [N-1:0] d, input op_e o,
                                            input logic sign, input int unsigned s);
    logic [N-1:0] r;
    r = d;
    case (o)
      OP_SLL: r = d << s;
      OP_SRL: r = d >> s;
      OP_SRA: r = (d >> s) | ({N{sign}} & ~({N{1'b1}} >> s));
      OP_ROL: r = (d << s) | (d >> (N - s));
      default: r = d;
    endcase
    return r;
  endfunction

  assign out_valid = g_stage[L-1].valid_q;
  assign out       = g_stage[L-1].data_q;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  for (genvar k = 0; k < L; k++) begin : g_stage
    localparam int unsigned S = 1 << k;

    // Stage k only needs shamt bits k..L-1; bit 0 of src_sh is its own select.
    logic [L-k-1:0] src_sh;
    logic [N-1:0]   src_data;
    op_e            src_op;
    logic           src_sign;
    logic           src_valid;

    logic [N-1:0] data_d, data_q;
    logic         valid_d, valid_q;

    if (k == 0) begin : g_src
      assign src_data  = in;
      assign src_sh    = shamt;
      assign src_op    = op_e'(op);
      assign src_sign  = in[N-1];
      assign src_valid = in_valid;
    end else begin : g_src
      assign src_data  = g_stage[k-1].data_q;
      assign src_sh    = g_stage[k-1].g_carry.sh_q;
      assign src_op    = g_stage[k-1].g_carry.op_q;
      assign src_sign  = g_stage[k-1].g_carry.sign_q;
      assign src_valid = g_stage[k-1].valid_q;
    end

    // NOTE: every always_comb output gets a default (hold) first, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (advance) begin
        valid_d = src_valid;
        data_d  = src_sh[0] ? shift_by(src_data, src_op, src_sign, S) : src_data;
      end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= data_d;
        valid_q <= valid_d;
      end
    end

    // The final stage only presents data; control fields stop one stage earlier.
    if (k < L - 1) begin : g_carry
      logic [L-k-2:0] sh_d, sh_q;
      op_e            op_d, op_q;
      logic           sign_d, sign_q;

      always_comb begin
        sh_d   = sh_q;
        op_d   = op_q;
        sign_d = sign_q;
        if (advance) begin
          sh_d   = src_sh[L-k-1:1];
          op_d   = src_op;
          sign_d = src_sign;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sh_q   <= '0;
          op_q   <= OP_SLL;
          sign_q <= 1'b0;
        end else begin
          sh_q   <= sh_d;
          op_q   <= op_d;
          sign_q <= sign_d;
        end
      end
    end
  end

endmodule

// File: doc/shifter_pipelined.md
Name: shifter_pipelined

Overview:
Parametrised, pipelined barrel shifter for the ALU datapath. Supports logical left, logical right, arithmetic right and rotate left at width N. Each log-shifter stage handles one bit of shamt, with a register after every stage, so timing closes at high clock rates. Uses a valid/ready handshake on input and output, so it can sit between stalling pipeline stages.

Parameters:
N, 32, data width in bits; power of two, N >= 4.
L, $clog2(N), number of shift stages and the pipeline latency in cycles; derived, not overridden.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input operands valid.
in_ready  output  1  block can accept an operation this cycle.
in  input  N  value to shift.
shamt  input  L  shift amount, 0..N-1, unsigned.
op  input  2  00 = SLL, 01 = SRL, 10 = SRA, 11 = ROL.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out  output  N  shifted result.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. On a clk edge with rst=1, all stage valid bits clear, all stage data and op registers clear to 0, out=0 and out_valid=0. in_ready=1 the cycle after reset deasserts.
- Structure: stages k=0..L-1.
  - Stage k shifts its operand by 2^k when shamt[k]=1; otherwise it passes the operand through.
  - Each stage registers data, the remaining shamt bits, op and a valid bit.
  - Stage L-1's register drives out and out_valid.
- Per-stage shift by s=2^k:
  - SLL: zero-fill at LSBs.
  - SRL: zero-fill at MSBs.
  - SRA: fill MSBs with the sign bit of the original in. The sign bit is captured at entry and carried down the pipeline.
  - ROL: bits leaving the MSB re-enter at the LSB.
- Handshake:
  - advance = !out_valid || out_ready; in_ready = advance. in_ready is purely combinational from out_valid/out_ready and does not depend on in_valid.
  - A transfer occurs when in_valid && in_ready. Stage 0 then captures the operands with valid=1.
  - When advance=1 and in_valid=0, stage 0 captures valid=0 (a bubble).
  - When advance=0, every stage holds: data, op and valid are all frozen.
  - Bubbles are not collapsed; the pipeline moves as a single unit.
- Latency: an operation accepted at edge t has out_valid=1 with its result after edge t+L-1, so it is visible L cycles after acceptance, provided no stall occurs. Each stall cycle adds 1.
- Throughput: one operation per cycle while out_ready=1.
- Ordering: results leave strictly in acceptance order.
- out and out_valid stay stable while out_valid=1 && out_ready=0. A result is dropped only on the edge where out_valid && out_ready.
- shamt=0: out equals in for every op.
- shamt=N-1, SRA of a negative value: out = all ones.
- Reset mid-operation: all in-flight operations are discarded, with no partial result. out_valid=0 on the next cycle.
- Simultaneous events:
  - With a full pipeline and out_ready=1, a new input is accepted in the same cycle that the oldest result retires.
  - If rst and in_valid are both asserted, rst wins.
- Combinational reference for verification:
  - SLL = in << shamt.
  - SRL = in >> shamt.
  - SRA = $signed(in) >>> shamt.
  - ROL = (in << shamt) | (in >> (N-shamt)), with shamt=0 giving in.

Test Plan:
- N=32. Send SLL 0x0000_0001 by 31, then SRL 0x8000_0000 by 4, then SRA 0x8000_0000 by 4, on consecutive cycles with out_ready=1. Required: out_valid pulses on 3 consecutive cycles, starting 5 cycles after the first acceptance, with values 0x8000_0000, 0x0800_0000, 0xF800_0000.
- ROL 0x8000_0001 by 1 -> 0x0000_0003. ROL 0x1234_5678 by 16 -> 0x5678_1234. SRA 0x7FFF_FFFF by 31 -> 0x0000_0000. Any op with shamt=0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Backpressure: stream 8 SLL ops (in=i, shamt=i) with out_ready=0 from cycle 3 to cycle 10. Required:
  - in_ready=0 whenever out_valid=1 && out_ready=0.
  - out stays frozen during the stall.
  - After release, exactly 8 results arrive in order, values i<<i; none lost or duplicated.
- Bubble handling: alternate in_valid 1/0 with out_ready=1. Required: out_valid alternates 1/0 with latency 5, and results are correct.
- Reset mid-flight: accept 3 ops, assert rst for 1 cycle before any result emerges. Required: out_valid=0 and out=0 after reset; no stale result ever appears; the next accepted op returns the correct result 5 cycles later.
- Randomized: 10k ops with random op/shamt/in and random out_ready, scoreboarded against the combinational reference. Repeat at N=8 and N=64.
